ibex_bus_responder: RTL and testbench

Memory-side responder for the core's instruction/data bus protocol (req/gnt/rvalid with integrity bits). It is the other end of the core's instr_* or data_* port. It is backed by a local word-addressed SRAM model with fixed, configurable response latency, bounded outstanding requests, optional grant throttling and an error window. It is used in simulation tops and FPGA bring-up in place of a real interconnect.

---
 rtl/ibex_bus_responder_pkg.sv | 27 ++
 rtl/ibex_bus_resp_pipe.sv | 31 +++
 rtl/ibex_bus_responder_chk.sv | 26 ++
 rtl/ibex_bus_responder.sv | 154 +++++++++++++++
 tb/tb_ibex_bus_responder.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/ibex_bus_responder_pkg.sv
// Shared types and integrity helper for the bus responder.
package ibex_bus_responder_pkg;

  // One response slot travelling through the latency pipeline.
  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] rdata;
  } bus_resp_t;

  // Check bits of the inverted code are XORed with this constant.
  localparam logic [6:0] LP_INTG_INV = 7'h2A;

  // Inverted SECDED(39,32) check bits for a 32-bit word.
  function automatic logic [6:0] prim_secded_inv_39_32_enc(input logic [31:0] i_data);
    logic [6:0] w_chk;
    w_chk[0] = ^(i_data & 32'h2606_BD25);
    w_chk[1] = ^(i_data & 32'hDEBA_8050);
    w_chk[2] = ^(i_data & 32'h413D_89AA);
    w_chk[3] = ^(i_data & 32'h3123_4ED1);
    w_chk[4] = ^(i_data & 32'hC2C1_323B);
    w_chk[5] = ^(i_data & 32'h2DCC_624C);
    w_chk[6] = ^(i_data & 32'h9850_5586);
    return w_chk ^ LP_INTG_INV;
  endfunction

endpackage

// File: rtl/ibex_bus_resp_pipe.sv
// Fixed-depth response delay line; slots are cleared by synchronous reset.
module ibex_bus_resp_pipe
  import ibex_bus_responder_pkg::*;
#(
  parameter int unsigned Depth = 1
) (
  input  logic      i_clk,
  input  logic      i_rst_n,
  input  bus_resp_t i_resp,
  output bus_resp_t o_resp
);

  bus_resp_t r_stage [Depth];

  // Shift responses one stage per cycle; reset drops everything in flight.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < int'(Depth); i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      r_stage[0] <= i_resp;
      for (int i = 1; i < int'(Depth); i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_resp = r_stage[Depth-1];

endmodule

// File: rtl/ibex_bus_responder_chk.sv
// Protocol and bookkeeping assertions for the bus responder.
module ibex_bus_responder_chk #(
  parameter int unsigned MaxOutstanding = 2
) (
  input logic        i_clk,
  input logic        i_rst_n,
  input logic        i_req,
  input logic        i_gnt,
  input logic        i_we,
  input logic [3:0]  i_be,
  input logic [31:0] i_addr,
  input logic [31:0] i_wdata,
  input logic        i_rvalid,
  input logic [2:0]  i_outstanding
);

  a_out_bound: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    i_outstanding <= 3'(MaxOutstanding));

  a_no_underflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    i_rvalid |-> (i_outstanding != 3'd0));

  a_req_stable: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (i_req && !i_gnt) |=> ($stable(i_we) && $stable(i_be) && $stable(i_addr) && $stable(i_wdata)));

endmodule

// File: rtl/ibex_bus_responder.sv
// Memory-side req/gnt/rvalid responder backed by a local word array.
module ibex_bus_responder
  import ibex_bus_responder_pkg::*;
#(
  parameter int unsigned MemSizeWords   = 1024,
  parameter logic [31:0] AddrBase       = 32'h0010_0000,
  parameter int unsigned ReadLatency    = 1,
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned GntStallPeriod = 0,
  parameter logic [31:0] ErrAddrBase    = 32'hFFFF_FFFF,
  parameter logic [31:0] ErrAddrMask    = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [6:0]  wdata_intg_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic [6:0]  rdata_intg_o,
  output logic        err_o,
  output logic        intg_err_o,
  output logic        busy_o
);

  localparam int unsigned LP_IDX_W      = $clog2(MemSizeWords);
  localparam logic [31:0] LP_RANGE_MASK = ~((32'(MemSizeWords) << 2) - 32'd1);
  localparam logic [2:0]  LP_MAX_OUT    = 3'(MaxOutstanding);
  localparam logic [15:0] LP_STALL_PER  = 16'(GntStallPeriod);

  logic [31:0]         r_mem [MemSizeWords];
  logic [2:0]          r_outstanding;
  logic [15:0]         r_gnt_cnt;
  logic                r_stall;
  bus_resp_t           w_pipe_in;
  bus_resp_t           w_pipe_out;
  logic [LP_IDX_W-1:0] w_idx;
  logic                w_in_range;
  logic                w_in_err_win;
  logic                w_intg_mismatch;
  logic                w_err;
  logic                w_rvalid;
  logic                w_gnt;
  logic [2:0]          w_out_after_rsp;
  logic [31:0]         w_rdata;

  // Decode: aligned base makes the range test a simple masked compare.
  assign w_idx           = addr_i[LP_IDX_W+1:2];
  assign w_in_range      = (addr_i & LP_RANGE_MASK) == AddrBase;
  assign w_in_err_win    = (addr_i & ~ErrAddrMask) == (ErrAddrBase & ~ErrAddrMask);
  assign w_intg_mismatch = prim_secded_inv_39_32_enc(wdata_i) != wdata_intg_i;
  assign w_err           = ~w_in_range | w_in_err_win | (we_i & w_intg_mismatch);

  // A slot retiring this cycle is already free for a new grant.
  assign w_rvalid        = w_pipe_out.valid & rst_ni;
  assign w_out_after_rsp = r_outstanding - {2'b00, w_rvalid};
  assign w_gnt           = rst_ni & req_i & ~r_stall & (w_out_after_rsp < LP_MAX_OUT);

  // Build the response for the request granted this cycle.
  always_comb begin
    w_pipe_in = '0;
    if (w_gnt) begin
      w_pipe_in.valid = 1'b1;
      w_pipe_in.err   = w_err;
      if (!w_err && !we_i) begin
        w_pipe_in.rdata = r_mem[w_idx];
      end else begin
        w_pipe_in.rdata = 32'h0000_0000;
      end
    end else begin
      w_pipe_in = '0;
    end
  end

  // Byte-enabled array write on an error-free write grant; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (w_gnt && we_i && !w_err) begin
      for (int i = 0; i < 4; i++) begin
        if (be_i[i]) begin
          r_mem[w_idx][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
    end
  end

  // Track granted-but-unanswered requests.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_outstanding <= 3'd0;
    end else begin
      r_outstanding <= r_outstanding + {2'b00, w_gnt} - {2'b00, w_rvalid};
    end
  end

  // Count grants and withhold gnt for one cycle after every period-th grant.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_gnt_cnt <= 16'd0;
      r_stall   <= 1'b0;
    end else if (LP_STALL_PER == 16'd0) begin
      r_gnt_cnt <= 16'd0;
      r_stall   <= 1'b0;
    end else if (w_gnt) begin
      if (r_gnt_cnt + 16'd1 == LP_STALL_PER) begin
        r_gnt_cnt <= 16'd0;
        r_stall   <= 1'b1;
      end else begin
        r_gnt_cnt <= r_gnt_cnt + 16'd1;
        r_stall   <= 1'b0;
      end
    end else begin
      r_stall <= 1'b0;
    end
  end

  ibex_bus_resp_pipe #(
    .Depth (ReadLatency)
  ) u_pipe (
    .i_clk   (clk_i),
    .i_rst_n (rst_ni),
    .i_resp  (w_pipe_in),
    .o_resp  (w_pipe_out)
  );

  ibex_bus_responder_chk #(
    .MaxOutstanding (MaxOutstanding)
  ) u_chk (
    .i_clk         (clk_i),
    .i_rst_n       (rst_ni),
    .i_req         (req_i),
    .i_gnt         (w_gnt),
    .i_we          (we_i),
    .i_be          (be_i),
    .i_addr        (addr_i),
    .i_wdata       (wdata_i),
    .i_rvalid      (w_rvalid),
    .i_outstanding (r_outstanding)
  );

  // Outputs are forced quiet while reset is held.
  assign w_rdata      = rst_ni ? w_pipe_out.rdata : 32'h0000_0000;
  assign gnt_o        = w_gnt;
  assign rvalid_o     = w_rvalid;
  assign rdata_o      = w_rdata;
  assign rdata_intg_o = prim_secded_inv_39_32_enc(w_rdata);
  assign err_o        = w_pipe_out.err & rst_ni;
  assign intg_err_o   = req_i & we_i & w_gnt & w_intg_mismatch;
  assign busy_o       = rst_ni & (r_outstanding != 3'd0);

endmodule

// File: tb/tb_ibex_bus_responder.sv
// Self-checking bench: queue-based behavioural model plus literal expectations.
module tb_ibex_bus_responder;

  localparam int          RL    = 3;
  localparam int          MAXO  = 2;
  localparam int          PER   = 0;
  localparam int          WORDS = 1024;
  localparam logic [31:0] BASE  = 32'h0010_0000;
  localparam logic [31:0] EBASE = 32'h0010_0F00;
  localparam logic [31:0] EMASK = 32'h0000_00FF;

  logic        clk = 1'b0;
  logic        rst_ni, req_i, we_i;
  logic [3:0]  be_i;
  logic [31:0] addr_i, wdata_i;
  logic [6:0]  wdata_intg_i;
  logic        gnt_o, rvalid_o, err_o, intg_err_o, busy_o;
  logic [31:0] rdata_o;
  logic [6:0]  rdata_intg_o;

  ibex_bus_responder #(
    .MemSizeWords(WORDS), .AddrBase(BASE), .ReadLatency(RL), .MaxOutstanding(MAXO),
    .GntStallPeriod(PER), .ErrAddrBase(EBASE), .ErrAddrMask(EMASK)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .req_i(req_i), .gnt_o(gnt_o), .we_i(we_i), .be_i(be_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .wdata_intg_i(wdata_intg_i), .rvalid_o(rvalid_o),
    .rdata_o(rdata_o), .rdata_intg_o(rdata_intg_o), .err_o(err_o), .intg_err_o(intg_err_o),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Inverted SECDED(39,32): parity over the published column masks, then invert bits 1,3,5.
  function automatic logic [6:0] enc(input logic [31:0] d);
    logic [31:0] m [7];
    logic [6:0]  c;
    m = '{32'h2606BD25, 32'hDEBA8050, 32'h413D89AA, 32'h31234ED1,
          32'hC2C1323B, 32'h2DCC624C, 32'h98505586};
    for (int k = 0; k < 7; k++) c[k] = ^(d & m[k]);
    return c ^ 7'h2A;
  endfunction

  typedef struct { int due; logic err; logic [31:0] data; } exp_t;
  typedef struct { int cyc; logic err; logic [31:0] data; } cap_t;
  exp_t        m_q[$];
  cap_t        cap_q[$];
  logic [31:0] m_mem [int];
  int          m_gcnt = 0;
  bit          m_stall = 0;

  // Compare process: predict every output from the model and advance it.
  always @(negedge clk) begin : cmp
    bit          e_rv, e_gnt, e_mis, e_err, in_rng, in_win;
    logic [31:0] d, nw;
    int          widx;
    if (!rst_ni) begin
      chk("rst_gnt", gnt_o, 0);      chk("rst_rvalid", rvalid_o, 0);
      chk("rst_busy", busy_o, 0);    chk("rst_err", err_o, 0);
      chk("rst_rdata", rdata_o, 0);  chk("rst_intg_err", intg_err_o, 0);
      chk("rst_rdata_intg", rdata_intg_o, enc(32'h0));
      m_q.delete(); m_gcnt = 0; m_stall = 0;
    end else begin
      e_rv  = (m_q.size() > 0) && (m_q[0].due == cyc);
      e_gnt = req_i && !m_stall && ((m_q.size() - (e_rv ? 1 : 0)) < MAXO);
      e_mis = (wdata_intg_i !== enc(wdata_i));
      chk("gnt", gnt_o, e_gnt);
      chk("rvalid", rvalid_o, e_rv);
      chk("busy", busy_o, m_q.size() != 0);
      chk("intg_err", intg_err_o, e_gnt && we_i && e_mis);
      chk("rdata_intg", rdata_intg_o, enc(rdata_o));
      if (e_rv) begin
        chk("rdata", rdata_o, m_q[0].data);
        chk("err", err_o, m_q[0].err);
        void'(m_q.pop_front());
      end
      if (rvalid_o === 1'b1) cap_q.push_back('{cyc, err_o, rdata_o});
      m_stall = 0;
      if (e_gnt) begin
        in_rng = (64'(addr_i) >= 64'(BASE)) && (64'(addr_i) < 64'(BASE) + 64'(WORDS * 4));
        in_win = (addr_i & ~EMASK) == (EBASE & ~EMASK);
        e_err  = !in_rng || in_win || (we_i && e_mis);
        widx   = int'((addr_i - BASE) >> 2);
        d      = 32'h0;
        if (!e_err && we_i) begin
          nw = m_mem.exists(widx) ? m_mem[widx] : 32'h0;
          for (int b = 0; b < 4; b++) if (be_i[b]) nw[8*b +: 8] = wdata_i[8*b +: 8];
          m_mem[widx] = nw;
        end else if (!e_err) begin
          d = m_mem.exists(widx) ? m_mem[widx] : 32'h0;
        end
        m_q.push_back('{cyc + RL, e_err, d});
        m_gcnt++;
        if (PER != 0 && m_gcnt == PER) begin m_stall = 1; m_gcnt = 0; end
      end
    end
  end

  logic last_ie;

  task automatic do_req(input logic we, input logic [3:0] be, input logic [31:0] addr,
                        input logic [31:0] wdata, input bit flip, output int gcyc, output int waits);
    we_i = we; be_i = be; addr_i = addr; wdata_i = wdata;
    wdata_intg_i = enc(wdata) ^ (flip ? 7'h01 : 7'h00);
    req_i = 1'b1; waits = 0; gcyc = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (gnt_o === 1'b1) begin gcyc = cyc; last_ie = intg_err_o; break; end
      waits++;
    end
    if (gcyc < 0) chk("grant_timeout", 0, 1);
    @(posedge clk); #1;
    req_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_resp(input int n);
    for (int k = 0; k < 60 && cap_q.size() < n; k++) @(posedge clk);
    #1;
    chk("resp_timeout", cap_q.size() >= n, 1);
  endtask

  int g, w, gr;
  int bw [6];
  int exp_w [6] = '{0, 0, 1, 0, 1, 0};

  initial begin
    rst_ni = 1'b0; req_i = 1'b0; we_i = 1'b0; be_i = 4'h0;
    addr_i = 32'h0; wdata_i = 32'h0; wdata_intg_i = 7'h0;
    chk("enc_zero", enc(32'h0), 7'h2A);
    chk("enc_one", enc(32'h1), 7'h33);
    repeat (3) @(posedge clk); #1;
    chk("rst_intg_lit", rdata_intg_o, 7'h2A);
    rst_ni = 1'b1; idle(2);

    // Full write then read: latency and data
    cap_q.delete();
    do_req(1'b1, 4'hF, 32'h0010_0010, 32'hDEADBEEF, 0, g, w);
    do_req(1'b0, 4'hF, 32'h0010_0010, 32'h0, 0, gr, w);
    wait_resp(2);
    chk("wr_resp_rdata", cap_q[0].data, 32'h0);
    chk("rd_data", cap_q[1].data, 32'hDEADBEEF);
    chk("rd_err", cap_q[1].err, 0);
    chk("rd_latency", cap_q[1].cyc - gr, RL);
    idle(4);

    // Partial write and be=0 no-op
    cap_q.delete();
    do_req(1'b1, 4'hF, 32'h0010_0020, 32'h11223344, 0, g, w);
    do_req(1'b1, 4'b0101, 32'h0010_0020, 32'hAABBCCDD, 0, g, w);
    do_req(1'b0, 4'h0, 32'h0010_0020, 32'h0, 0, g, w);
    do_req(1'b1, 4'h0, 32'h0010_0020, 32'hFFFFFFFF, 0, g, w);
    do_req(1'b0, 4'hF, 32'h0010_0020, 32'h0, 0, g, w);
    wait_resp(5);
    chk("partial_data", cap_q[2].data, 32'h11BB33DD);
    chk("be0_err", cap_q[3].err, 0);
    chk("be0_nochange", cap_q[4].data, 32'h11BB33DD);
    idle(4);

    // Held request burst against the outstanding limit
    for (int i = 0; i < 6; i++) do_req(1'b1, 4'hF, 32'h0010_0040 + 32'(4 * i), 32'hA000_0000 + 32'(i), 0, g, w);
    idle(6);
    cap_q.delete();
    for (int i = 0; i < 6; i++) do_req(1'b0, 4'hF, 32'h0010_0040 + 32'(4 * i), 32'h0, 0, g, bw[i]);
    wait_resp(6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("burst_wait%0d", i), bw[i], exp_w[i]);
      chk($sformatf("burst_data%0d", i), cap_q[i].data, 32'hA000_0000 + 32'(i));
    end
    idle(4);

    // Error responses: out of range, window, boundaries; array unchanged
    cap_q.delete();
    do_req(1'b0, 4'hF, 32'h0000_0000, 32'h0, 0, g, w);
    do_req(1'b0, 4'hF, 32'h0010_0F10, 32'h0, 0, g, w);
    do_req(1'b0, 4'hF, 32'h0010_1000, 32'h0, 0, g, w);
    do_req(1'b0, 4'hF, 32'h000F_FFFC, 32'h0, 0, g, w);
    do_req(1'b1, 4'hF, 32'h0000_0010, 32'h12345678, 0, g, w);
    do_req(1'b0, 4'hF, 32'h0010_0010, 32'h0, 0, g, w);
    do_req(1'b1, 4'hF, 32'h0010_0EFC, 32'hCAFEF00D, 0, g, w);
    do_req(1'b0, 4'hF, 32'h0010_0EFC, 32'h0, 0, g, w);
    wait_resp(8);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("err_flag%0d", i), cap_q[i].err, 1);
      chk($sformatf("err_rdata%0d", i), cap_q[i].data, 32'h0);
    end
    chk("oor_write_noalias", cap_q[5].data, 32'hDEADBEEF);
    chk("last_ok_word", cap_q[7].data, 32'hCAFEF00D);
    chk("last_ok_err", cap_q[7].err, 0);
    idle(4);

    // Write with corrupted integrity bits
    cap_q.delete();
    do_req(1'b1, 4'hF, 32'h0010_0010, 32'h55555555, 1, g, w);
    chk("intg_err_pulse", last_ie, 1);
    do_req(1'b0, 4'hF, 32'h0010_0010, 32'h0, 0, g, w);
    wait_resp(2);
    chk("intg_err_resp", cap_q[0].err, 1);
    chk("intg_word_kept", cap_q[1].data, 32'hDEADBEEF);
    idle(4);

    // Reset with two requests outstanding
    cap_q.delete();
    do_req(1'b0, 4'hF, 32'h0010_0040, 32'h0, 0, g, w);
    do_req(1'b0, 4'hF, 32'h0010_0044, 32'h0, 0, g, w);
    rst_ni = 1'b0;
    idle(2);
    rst_ni = 1'b1;
    idle(5);
    chk("rst_dropped", cap_q.size(), 0);
    do_req(1'b0, 4'hF, 32'h0010_0020, 32'h0, 0, g, w);
    wait_resp(1);
    chk("post_rst_data", cap_q[0].data, 32'h11BB33DD);
    idle(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
